wrapper_misr: RTL and testbench

Memory-mapped MISR (multiple-input signature register) peripheral on the core's 64-bit data bus. It sits beside the SRAM at START_ADDR (just above the 32 MiB SRAM window). It snoops every bus request that targets addresses outside its own register window and compacts the request data into a signature. Software programs the feedback polynomial, enables or clears it, and reads back the signature and a done flag through four registers.

---
 rtl/misr_pkg.sv | 42 ++++
 rtl/misr_core.sv | 50 +++++
 rtl/wrapper_misr.sv | 113 +++++++++++
 tb/tb_wrapper_misr.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/misr_pkg.sv
// -----------------------------------------------------------------------------
// misr_pkg
// Shared constants and types for the wrapper_misr peripheral.
//   - register offsets inside the 256-byte window
//   - window size
//   - CONTROL bit positions
//   - decoded register select type and its decode function
// -----------------------------------------------------------------------------
package misr_pkg;

  localparam logic [7:0] CONTROL_OFFSET   = 8'h00;
  localparam logic [7:0] COEFF_OFFSET     = 8'h40;
  localparam logic [7:0] SIGNATURE_OFFSET = 8'h80;
  localparam logic [7:0] DONE_OFFSET      = 8'hC0;

  localparam int unsigned WINDOW_SIZE = 'h100;

  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_CLR_BIT = 1;

  // Compaction counter width; must hold NBIT_REGS (64) without wrapping.
  localparam int unsigned CNT_W = 7;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CONTROL,
    SEL_COEFF,
    SEL_SIGNATURE,
    SEL_DONE
  } reg_sel_e;

  function automatic reg_sel_e decode_offset(input logic [7:0] offset);
    case (offset)
      CONTROL_OFFSET:   return SEL_CONTROL;
      COEFF_OFFSET:     return SEL_COEFF;
      SIGNATURE_OFFSET: return SEL_SIGNATURE;
      DONE_OFFSET:      return SEL_DONE;
      default:          return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/misr_core.sv
// -----------------------------------------------------------------------------
// misr_core
// Signature register, compaction counter and DONE flag.
// Ports:
//   clk_i   clock, rising edge
//   rst_i   synchronous active-high reset
//   step    perform one compaction this cycle (ignored once done)
//   clear   zero signature and counter (wins over step)
//   coeff   feedback polynomial taps
//   in      compaction input word
//   sig     current signature
//   done    NBIT_REGS compactions completed since last clear/reset
// -----------------------------------------------------------------------------
module misr_core
  import misr_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         step,
  input  logic         clear,
  input  logic [N-1:0] coeff,
  input  logic [N-1:0] in,
  output logic [N-1:0] sig,
  output logic         done
);

  logic [CNT_W-1:0] count;

  // The counter stops at N, so DONE is simply "counter reached N" and the
  // signature freezes because further steps are suppressed.
  assign done = (count == CNT_W'(N));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others; blocking here would chain updates.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sig   <= '0;
      count <= '0;
    end else if (clear) begin
      sig   <= '0;
      count <= '0;
    end else if (step && !done) begin
      sig   <= {sig[N-2:0], 1'b0} ^ (sig[N-1] ? coeff : '0) ^ in;
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/wrapper_misr.sv
// -----------------------------------------------------------------------------
// wrapper_misr
// Memory-mapped MISR peripheral. Snoops every bus request outside its own
// 256-byte window at START_ADDR and compacts the request data into a
// signature. Registers: CONTROL (0x00), COEFF (0x40), SIGNATURE (0x80, RO),
// DONE (0xC0, RO).
// Ports:
//   clk_i   clock, rising edge
//   rst_i   synchronous active-high reset
//   req_i   bus request valid
//   we_i    1 = write, 0 = read
//   data_i  write data / snooped data
//   addr_i  request address
//   data_o  registered read data, 0 except the cycle after an in-window read
// Build option:
//   MISR_ADDR_COMPACT_EN  when defined, compaction input is data_i ^ addr_i;
//                         otherwise data_i alone.
// -----------------------------------------------------------------------------
module wrapper_misr
  import misr_pkg::*;
#(
  parameter int unsigned              NBIT_DATA  = 64,
  parameter int unsigned              NBIT_ADDR  = 64,
  parameter int unsigned              NBIT_REGS  = NBIT_DATA,
  parameter logic [NBIT_ADDR-1:0]     START_ADDR = NBIT_ADDR'(64'h0000_0000_0200_0000)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [NBIT_DATA-1:0] data_i,
  input  logic [NBIT_ADDR-1:0] addr_i,
  output logic [NBIT_DATA-1:0] data_o
);

  localparam logic [NBIT_ADDR-1:0] END_ADDR = START_ADDR + NBIT_ADDR'(WINDOW_SIZE);

  logic                 in_window;
  logic [7:0]           offset;
  reg_sel_e             sel;
  logic                 wr_hit;
  logic                 rd_hit;
  logic                 ctrl_en;
  logic [NBIT_REGS-1:0] coeff;
  logic                 clear;
  logic                 step;
  logic [NBIT_REGS-1:0] comp_in;
  logic [NBIT_REGS-1:0] sig;
  logic                 done;

  assign in_window = (addr_i >= START_ADDR) && (addr_i < END_ADDR);
  // The window is 256-byte aligned in practice, but subtracting keeps the
  // decode correct for any base.
  assign offset    = addr_i[7:0] - START_ADDR[7:0];
  assign sel       = decode_offset(offset);
  assign wr_hit    = req_i && we_i && in_window;
  assign rd_hit    = req_i && !we_i && in_window;

  // CLR is never stored: it is a one-cycle pulse straight into the core.
  assign clear = wr_hit && (sel == SEL_CONTROL) && data_i[CTRL_CLR_BIT];
  assign step  = req_i && !in_window && ctrl_en;

`ifdef MISR_ADDR_COMPACT_EN
  assign comp_in = data_i ^ addr_i[NBIT_DATA-1:0];
`else
  assign comp_in = data_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_en <= 1'b0;
      coeff   <= '0;
    end else if (wr_hit) begin
      case (sel)
        SEL_CONTROL: ctrl_en <= data_i[CTRL_EN_BIT];
        SEL_COEFF:   coeff   <= data_i;
        default:     ;
      endcase
    end
  end

  // Read data is registered; it shows the pre-edge register value, so a read
  // in the same cycle as a step returns the pre-step signature.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o <= '0;
    end else if (rd_hit) begin
      case (sel)
        SEL_CONTROL:   data_o <= NBIT_DATA'(ctrl_en);
        SEL_COEFF:     data_o <= coeff;
        SEL_SIGNATURE: data_o <= sig;
        SEL_DONE:      data_o <= NBIT_DATA'(done);
        default:       data_o <= '0;
      endcase
    end else begin
      data_o <= '0;
    end
  end

  misr_core #(
    .N (NBIT_REGS)
  ) u_core (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .step  (step),
    .clear (clear),
    .coeff (coeff),
    .in    (comp_in),
    .sig   (sig),
    .done  (done)
  );

endmodule

// File: tb/tb_wrapper_misr.sv
// -----------------------------------------------------------------------------
// tb_wrapper_misr
// Self-checking bench for wrapper_misr. Expected read data is pushed to a
// scoreboard queue when a read is issued and popped when data_o presents it.
// -----------------------------------------------------------------------------
module tb_wrapper_misr;

  localparam logic [63:0] START = 64'h0000_0000_0200_0000;
  localparam logic [63:0] A_CTRL = START + 64'h00;
  localparam logic [63:0] A_COEF = START + 64'h40;
  localparam logic [63:0] A_SIG  = START + 64'h80;
  localparam logic [63:0] A_DONE = START + 64'hC0;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i  = 1'b0;
  logic [63:0] data_i = '0;
  logic [63:0] addr_i = '0;
  logic [63:0] data_o;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [63:0] sb[$];
  logic [63:0] got;
  logic [63:0] exp_v;

  always #5 clk_i = ~clk_i;

  wrapper_misr dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req_i  (req_i),
    .we_i   (we_i),
    .data_i (data_i),
    .addr_i (addr_i),
    .data_o (data_o)
  );

  // Drive one bus cycle, then return 1 ns after the sampling edge.
  task automatic bus(input logic req, input logic we, input logic [63:0] addr,
                     input logic [63:0] data);
    req_i  = req;
    we_i   = we;
    addr_i = addr;
    data_i = data;
    @(posedge clk_i);
    #1;
    req_i  = 1'b0;
    we_i   = 1'b0;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    logic [63:0] addrs [4];
    addrs = '{A_CTRL, A_COEF, A_SIG, A_DONE};
    rst_i = 1'b1;
    bus(1'b0, 1'b0, '0, '0);
    sb.push_back(64'h0);
    bus(1'b1, 1'b0, A_CTRL, '0);
    got = data_o; exp_v = sb.pop_front(); n_cmp++;
    if (got !== exp_v) begin
      n_fail++; $display("FAIL reset_data_o got=%h exp=%h", got, exp_v);
    end
    rst_i = 1'b0;
    foreach (addrs[i]) begin
      sb.push_back(64'h0);
      bus(1'b1, 1'b0, addrs[i], '0);
      got = data_o; exp_v = sb.pop_front(); n_cmp++;
      if (got !== exp_v) begin
        n_fail++; $display("FAIL reset_reg%0d got=%h exp=%h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_pre_enable();
    bus(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, rand64());
    got = data_o; n_cmp++;
    if (got !== 64'h0) begin
      n_fail++; $display("FAIL idle_data_o got=%h exp=0", got);
    end
    sb.push_back(64'h0);
    bus(1'b1, 1'b0, A_SIG, '0);
    got = data_o; exp_v = sb.pop_front(); n_cmp++;
    if (got !== exp_v) begin
      n_fail++; $display("FAIL pre_en_sig got=%h exp=%h", got, exp_v);
    end
    sb.push_back(64'h0);
    bus(1'b1, 1'b0, A_DONE, '0);
    got = data_o; exp_v = sb.pop_front(); n_cmp++;
    if (got !== exp_v) begin
      n_fail++; $display("FAIL pre_en_done got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_fill();
    bus(1'b1, 1'b1, A_CTRL, 64'h3);
    bus(1'b1, 1'b1, A_COEF, 64'h0);
    for (int i = 0; i < 64; i++)
      bus(1'b1, 1'($urandom_range(1)), 64'h1000 + 64'(i * 8), 64'h1);
    sb.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    bus(1'b1, 1'b0, A_SIG, '0);
    got = data_o; exp_v = sb.pop_front(); n_cmp++;
    if (got !== exp_v) begin
      n_fail++; $display("FAIL fill_sig got=%h exp=%h", got, exp_v);
    end
    sb.push_back(64'h1);
    bus(1'b1, 1'b0, A_DONE, '0);
    got = data_o; exp_v = sb.pop_front(); n_cmp++;
    if (got !== exp_v) begin
      n_fail++; $display("FAIL fill_done got=%h exp=%h", got, exp_v);
    end
    // 65th request must not change the frozen signature.
    bus(1'b1, 1'b1, 64'h2000, 64'h1);
    sb.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    bus(1'b1, 1'b0, A_SIG, '0);
    got = data_o; exp_v = sb.pop_front(); n_cmp++;
    if (got !== exp_v) begin
      n_fail++; $display("FAIL frozen_sig got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_feedback();
    bus(1'b1, 1'b1, A_CTRL, 64'h3);
    bus(1'b1, 1'b1, A_COEF, 64'h1B);
    bus(1'b1, 1'b0, 64'h3000, 64'h8000_0000_0000_0000);
    bus(1'b1, 1'b1, 64'h3008, 64'h0);
    // Back-to-back reads: each result appears one cycle after its request.
    sb.push_back(64'h1B);
    bus(1'b1, 1'b0, A_SIG, '0);
    got = data_o; exp_v = sb.pop_front(); n_cmp++;
    if (got !== exp_v) begin
      n_fail++; $display("FAIL feedback_sig got=%h exp=%h", got, exp_v);
    end
    sb.push_back(64'h1B);
    bus(1'b1, 1'b0, A_COEF, '0);
    got = data_o; exp_v = sb.pop_front(); n_cmp++;
    if (got !== exp_v) begin
      n_fail++; $display("FAIL coeff_rd got=%h exp=%h", got, exp_v);
    end
    sb.push_back(64'h1);
    bus(1'b1, 1'b0, A_CTRL, '0);
    got = data_o; exp_v = sb.pop_front(); n_cmp++;
    if (got !== exp_v) begin
      n_fail++; $display("FAIL ctrl_clr_selfclear got=%h exp=%h", got, exp_v);
    end
    sb.push_back(64'h0);
    bus(1'b1, 1'b0, A_DONE, '0);
    got = data_o; exp_v = sb.pop_front(); n_cmp++;
    if (got !== exp_v) begin
      n_fail++; $display("FAIL feedback_done got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_regs();
    sb.push_back(64'h0);
    bus(1'b1, 1'b0, START + 64'h20, '0);
    got = data_o; exp_v = sb.pop_front(); n_cmp++;
    if (got !== exp_v) begin
      n_fail++; $display("FAIL unmapped_rd got=%h exp=%h", got, exp_v);
    end
    bus(1'b1, 1'b1, A_SIG, rand64());
    bus(1'b1, 1'b1, A_DONE, 64'hFFFF_FFFF_FFFF_FFFF);
    bus(1'b1, 1'b1, START + 64'h20, 64'hDEAD_BEEF);
    sb.push_back(64'h1B);
    bus(1'b1, 1'b0, A_SIG, '0);
    got = data_o; exp_v = sb.pop_front(); n_cmp++;
    if (got !== exp_v) begin
      n_fail++; $display("FAIL sig_write_ignored got=%h exp=%h", got, exp_v);
    end
    sb.push_back(64'h0);
    bus(1'b1, 1'b0, A_DONE, '0);
    got = data_o; exp_v = sb.pop_front(); n_cmp++;
    if (got !== exp_v) begin
      n_fail++; $display("FAIL done_write_ignored got=%h exp=%h", got, exp_v);
    end
    sb.push_back(64'h0);
    bus(1'b1, 1'b0, START + 64'h20, '0);
    got = data_o; exp_v = sb.pop_front(); n_cmp++;
    if (got !== exp_v) begin
      n_fail++; $display("FAIL unmapped_after_wr got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_window_edges();
    bus(1'b1, 1'b1, A_CTRL, 64'h3);
    bus(1'b1, 1'b1, A_COEF, 64'h0);
    bus(1'b1, 1'b1, START - 64'h1, 64'h1);       // out of window: step
    bus(1'b1, 1'b1, START + 64'h100, 64'h4);     // out of window: step
    bus(1'b1, 1'b1, START + 64'hFF, 64'hFFFF);   // in window: no step
    // Undefined build: 1 -> 2^4 = 6. Address build XORs in the addresses.
`ifdef MISR_ADDR_COMPACT_EN
    exp_v = (((64'h1 ^ (START - 64'h1)) << 1) ^ (64'h4 ^ (START + 64'h100)));
`else
    exp_v = 64'h6;
`endif
    sb.push_back(exp_v);
    bus(1'b1, 1'b0, A_SIG, '0);
    got = data_o; exp_v = sb.pop_front(); n_cmp++;
    if (got !== exp_v) begin
      n_fail++; $display("FAIL window_edges got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_addr_compact();
    bus(1'b1, 1'b1, A_CTRL, 64'h3);
    bus(1'b1, 1'b1, A_COEF, 64'h0);
    bus(1'b1, 1'b1, 64'hF0, 64'hA5);
`ifdef MISR_ADDR_COMPACT_EN
    sb.push_back(64'h55);
`else
    sb.push_back(64'hA5);
`endif
    bus(1'b1, 1'b0, A_SIG, '0);
    got = data_o; exp_v = sb.pop_front(); n_cmp++;
    if (got !== exp_v) begin
      n_fail++; $display("FAIL addr_compact got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] addrs [4];
    addrs = '{A_CTRL, A_COEF, A_SIG, A_DONE};
    bus(1'b1, 1'b1, A_CTRL, 64'h3);
    bus(1'b1, 1'b1, A_COEF, 64'h1B);
    for (int i = 0; i < 5; i++) bus(1'b1, 1'b0, 64'h4000 + 64'(i), rand64());
    rst_i = 1'b1;
    bus(1'b1, 1'b0, 64'h5000, 64'hFFFF_FFFF_FFFF_FFFF);
    rst_i = 1'b0;
    foreach (addrs[i]) begin
      sb.push_back(64'h0);
      bus(1'b1, 1'b0, addrs[i], '0);
      got = data_o; exp_v = sb.pop_front(); n_cmp++;
      if (got !== exp_v) begin
        n_fail++; $display("FAIL mid_reset_reg%0d got=%h exp=%h", i, got, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pre_enable();
    test_fill();
    test_feedback();
    test_regs();
    test_window_edges();
    test_addr_compact();
    test_reset_mid_run();
    if (sb.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL scoreboard_drain got=%0d left exp=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
